// File: rtl/store_pkg.sv
// Shared state encoding and counter limits for the checkout tally block.
package store_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        ALARM = 2'd2
    } state_t;

    localparam int CNT_W    = 8;
    localparam int STOLEN_W = 4;

    localparam logic [CNT_W-1:0]    CNT_MAX    = 8'd255;
    localparam logic [STOLEN_W-1:0] STOLEN_MAX = 4'd15;
endpackage

// File: rtl/seg7_hex.sv
// Hex digit to active-low seven-segment decoder (bit 6 = g ... bit 0 = a).
module seg7_hex (
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);
    always_comb begin
        case (hex_i)
            4'h0:    seg_o = 7'b1000000;
            4'h1:    seg_o = 7'b1111001;
            4'h2:    seg_o = 7'b0100100;
            4'h3:    seg_o = 7'b0110000;
            4'h4:    seg_o = 7'b0011001;
            4'h5:    seg_o = 7'b0010010;
            4'h6:    seg_o = 7'b0000010;
            4'h7:    seg_o = 7'b1111000;
            4'h8:    seg_o = 7'b0000000;
            4'h9:    seg_o = 7'b0010000;
            4'hA:    seg_o = 7'b0001000;
            4'hB:    seg_o = 7'b0000011;
            4'hC:    seg_o = 7'b1000110;
            4'hD:    seg_o = 7'b0100001;
            4'hE:    seg_o = 7'b0000110;
            default: seg_o = 7'b0001110;
        endcase
    end
endmodule

// File: rtl/checkout_tally.sv
// Checkout tally: synchronises the scan key, classifies each presented item
// and keeps saturating per-customer counts of paid, discounted and stolen items.
module checkout_tally
    import store_pkg::*;
(
    input  logic                CLOCK_50,
    input  logic                reset_n,
    input  logic                scan,
    input  logic                stolen,
    input  logic                discounted,
    input  logic                clear,
    output logic [CNT_W-1:0]    item_count,
    output logic [CNT_W-1:0]    disc_count,
    output logic [STOLEN_W-1:0] stolen_count,
    output logic                alarm,
    output logic [6:0]          HEX0,
    output logic [6:0]          HEX1
);
    logic                s1_q, s2_q, s3_q;
    logic                armed_q;
    logic                stolenFlag_q, discFlag_q;
    state_t              state_q;
    logic [CNT_W-1:0]    itemCount_q, discCount_q;
    logic [STOLEN_W-1:0] stolenCount_q;
    logic                alarm_q;

    logic                scanEdge;
    logic [CNT_W-1:0]    itemInc, discInc;
    logic [STOLEN_W-1:0] stolenInc;

    // armed_q re-arms only after the synchronised key has been low for two
    // consecutive cycles, so a one-cycle dropout cannot create a second event.
    assign scanEdge = s2_q & ~s3_q & armed_q;

    assign itemInc   = (itemCount_q   == CNT_MAX)    ? itemCount_q   : itemCount_q   + 1'b1;
    assign discInc   = (discCount_q   == CNT_MAX)    ? discCount_q   : discCount_q   + 1'b1;
    assign stolenInc = (stolenCount_q == STOLEN_MAX) ? stolenCount_q : stolenCount_q + 1'b1;

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            armed_q      <= 1'b1;
            stolenFlag_q <= 1'b0;
            discFlag_q   <= 1'b0;
        end else begin
            s1_q <= scan;
            s2_q <= s1_q;
            s3_q <= s2_q;
            if (scanEdge) begin
                armed_q      <= 1'b0;
                stolenFlag_q <= stolen;
                discFlag_q   <= discounted;
            end else if (!s2_q && !s3_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    // In IDLE a clear takes priority over a coincident scan, which is dropped.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            itemCount_q   <= '0;
            discCount_q   <= '0;
            stolenCount_q <= '0;
            alarm_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clear) begin
                        itemCount_q   <= '0;
                        discCount_q   <= '0;
                        stolenCount_q <= '0;
                    end else if (scanEdge) begin
                        if (stolen) begin
                            state_q       <= ALARM;
                            alarm_q       <= 1'b1;
                            stolenCount_q <= stolenInc;
                        end else begin
                            state_q <= COUNT;
                        end
                    end
                end
                COUNT: begin
                    itemCount_q <= itemInc;
                    if (discFlag_q) begin
                        discCount_q <= discInc;
                    end
                    state_q <= IDLE;
                end
                ALARM: begin
                    if (clear) begin
                        state_q <= IDLE;
                        alarm_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    alarm_q <= 1'b0;
                end
            endcase
        end
    end

    assign item_count   = itemCount_q;
    assign disc_count   = discCount_q;
    assign stolen_count = stolenCount_q;
    assign alarm        = alarm_q;

    seg7_hex uHex0 (
        .hex_i (itemCount_q[3:0]),
        .seg_o (HEX0)
    );

    seg7_hex uHex1 (
        .hex_i (itemCount_q[7:4]),
        .seg_o (HEX1)
    );
endmodule

// File: tb/tb_checkout_tally.sv
// Randomised self-checking bench for checkout_tally against a per-scan tally model.
module tb_checkout_tally;
    logic       CLOCK_50;
    logic       reset_n;
    logic       scan;
    logic       stolen;
    logic       discounted;
    logic       clear;
    logic [7:0] item_count;
    logic [7:0] disc_count;
    logic [3:0] stolen_count;
    logic       alarm;
    logic [6:0] HEX0;
    logic [6:0] HEX1;

    int compareCount  = 0;
    int mismatchCount = 0;

    // Reference model: customer tallies and whether an alarm is outstanding.
    int mItems  = 0;
    int mDisc   = 0;
    int mStolen = 0;
    bit mAlarm  = 0;

    checkout_tally dut (
        .CLOCK_50     (CLOCK_50),
        .reset_n      (reset_n),
        .scan         (scan),
        .stolen       (stolen),
        .discounted   (discounted),
        .clear        (clear),
        .item_count   (item_count),
        .disc_count   (disc_count),
        .stolen_count (stolen_count),
        .alarm        (alarm),
        .HEX0         (HEX0),
        .HEX1         (HEX1)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic int satAdd(input int v, input int maxVal);
        return (v >= maxVal) ? maxVal : v + 1;
    endfunction

    function automatic logic [6:0] hexSeg(input int v);
        case (v & 15)
            0:  return 7'h40;
            1:  return 7'h79;
            2:  return 7'h24;
            3:  return 7'h30;
            4:  return 7'h19;
            5:  return 7'h12;
            6:  return 7'h02;
            7:  return 7'h78;
            8:  return 7'h00;
            9:  return 7'h10;
            10: return 7'h08;
            11: return 7'h03;
            12: return 7'h46;
            13: return 7'h21;
            14: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".items"},  item_count,   mItems);
        checkOutput({tag, ".disc"},   disc_count,   mDisc);
        checkOutput({tag, ".stolen"}, stolen_count, mStolen);
        checkOutput({tag, ".alarm"},  alarm,        mAlarm);
        checkOutput({tag, ".hex0"},   HEX0,         hexSeg(mItems));
        checkOutput({tag, ".hex1"},   HEX1,         hexSeg(mItems / 16));
    endtask

    // One item presentation: scan high for 'hold' cycles, then low long enough to re-arm.
    task automatic applyStimulus(input bit st, input bit d, input int hold);
        int oldItems;
        @(negedge CLOCK_50);
        scan       = 1'b1;
        stolen     = st;
        discounted = d;
        oldItems   = mItems;
        if (!mAlarm) begin
            if (st) begin
                mAlarm  = 1;
                mStolen = satAdd(mStolen, 15);
            end else begin
                mItems = satAdd(mItems, 255);
                if (d) mDisc = satAdd(mDisc, 255);
            end
        end
        repeat (3) @(posedge CLOCK_50);
        #1;
        checkOutput("alarmAtK2", alarm, mAlarm);
        checkOutput("itemsAtK2", item_count, oldItems);
        @(posedge CLOCK_50);
        #1;
        checkOutput("itemsAtK3", item_count, mItems);
        checkOutput("discAtK3",  disc_count, mDisc);
        repeat (hold - 3) @(negedge CLOCK_50);
        scan = 1'b0;
        repeat (4) @(negedge CLOCK_50);
    endtask

    task automatic pulseClear();
        @(negedge CLOCK_50);
        clear = 1'b1;
        @(negedge CLOCK_50);
        clear = 1'b0;
        if (mAlarm) begin
            mAlarm = 0;
        end else begin
            mItems  = 0;
            mDisc   = 0;
            mStolen = 0;
        end
        @(negedge CLOCK_50);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        reset_n    = 1'b0;
        scan       = 1'b0;
        stolen     = 1'b0;
        discounted = 1'b0;
        clear      = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        checkAll("reset");
        reset_n = 1'b1;
        repeat (2) @(negedge CLOCK_50);
        checkAll("postReset");

        applyStimulus(0, 0, 4);
        applyStimulus(0, 1, 4);
        applyStimulus(0, 1, 5);
        checkAll("threeScans");
        checkOutput("threeScans.items3", item_count, 3);
        checkOutput("threeScans.hex0is3", HEX0, 7'h30);

        applyStimulus(1, 0, 4);
        applyStimulus(0, 1, 4);
        applyStimulus(1, 1, 3);
        checkAll("alarmIgnores");
        pulseClear();
        checkAll("alarmCleared");

        applyStimulus(0, 0, 50);
        checkAll("heldScan");
        @(negedge CLOCK_50);
        scan = 1'b1;
        repeat (6) @(negedge CLOCK_50);
        scan = 1'b0;
        @(negedge CLOCK_50);
        scan = 1'b1;
        repeat (6) @(negedge CLOCK_50);
        scan = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        mItems = satAdd(mItems, 255);
        checkAll("shortDropout");

        pulseClear();
        for (int i = 0; i < 260; i++) applyStimulus(0, 1, 3);
        checkOutput("satItems", item_count, 255);
        checkOutput("satDisc", disc_count, 255);
        checkAll("saturated");
        for (int i = 0; i < 17; i++) begin
            applyStimulus(1, 0, 3);
            pulseClear();
        end
        checkOutput("satStolen", stolen_count, 15);
        checkAll("stolenSaturated");
        pulseClear();

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 9) < 2) begin
                pulseClear();
            end else begin
                applyStimulus(($urandom_range(0, 3) == 0), $urandom_range(0, 1), $urandom_range(3, 8));
            end
            checkAll("random");
        end

        if (mAlarm) pulseClear();
        pulseClear();
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 3);
        checkOutput("beforeOverlap.items5", item_count, 5);
        @(negedge CLOCK_50);
        scan       = 1'b1;
        stolen     = 1'b0;
        discounted = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        clear = 1'b1;
        @(negedge CLOCK_50);
        clear = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        scan = 1'b0;
        repeat (4) @(negedge CLOCK_50);
        mItems  = 0;
        mDisc   = 0;
        mStolen = 0;
        checkAll("clearWinsOverlap");
        applyStimulus(0, 0, 3);
        checkAll("idleAfterOverlap");

        pulseClear();
        for (int i = 0; i < 7; i++) applyStimulus(0, 0, 3);
        applyStimulus(1, 0, 3);
        checkAll("alarmBeforeReset");
        @(negedge CLOCK_50);
        reset_n = 1'b0;
        #1;
        mItems  = 0;
        mDisc   = 0;
        mStolen = 0;
        mAlarm  = 0;
        checkAll("asyncReset");
        scan   = 1'b1;
        stolen = 1'b0;
        @(negedge CLOCK_50);
        reset_n = 1'b1;
        repeat (4) @(negedge CLOCK_50);
        scan = 1'b0;
        repeat (5) @(negedge CLOCK_50);
        mItems = 1;
        checkAll("scanHighAtRelease");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end
endmodule

// File: doc/checkout_tally.md
CHECKOUT_TALLY -- requirements
Module: checkout_tally

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 SHALL have port CLOCK_50, input, 1 bit: system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port scan, input, 1 bit: asynchronous level from the checkout key; high means item presented.
REQ-005 SHALL have port stolen, input, 1 bit: level from the upstream item classifier; 1 means item not paid.
REQ-006 SHALL have port discounted, input, 1 bit: level from the upstream item classifier; 1 means discount item.
REQ-007 SHALL have port clear, input, 1 bit: synchronous one-cycle pulse; acknowledges an alarm or starts a new customer.
REQ-008 SHALL have port item_count, output, 8 bits: paid items this customer.
REQ-009 SHALL have port disc_count, output, 8 bits: discounted items this customer.
REQ-010 SHALL have port stolen_count, output, 4 bits: alarm events this customer.
REQ-011 SHALL have port alarm, output, 1 bit: high while in ALARM.
REQ-012 SHALL have ports HEX0 and HEX1, output, 7 bits each: active-low segments showing item_count low and high nibble in hex.

Function
REQ-013 SHALL synchronise scan through two flops (s1, s2), then register s2 as s3; scan_edge = s2 & ~s3.
REQ-014 SHALL sample stolen and discounted into flag registers in the cycle scan_edge is true, not at any other time.
REQ-015 SHALL implement FSM states IDLE, COUNT and ALARM.
REQ-016 IDLE: scan_edge with stolen=1 SHALL go to ALARM, scan_edge with stolen=0 SHALL go to COUNT, otherwise stay in IDLE.
REQ-017 COUNT SHALL last exactly one cycle, increment item_count, increment disc_count when the sampled discounted flag is 1, then return to IDLE.
REQ-018 Entry into ALARM SHALL increment stolen_count once; item_count and disc_count SHALL be unchanged.
REQ-019 ALARM SHALL ignore scan_edge, and clear SHALL return to IDLE with all counters preserved.
REQ-020 clear in IDLE SHALL zero item_count, disc_count and stolen_count on the next edge.
REQ-021 clear in COUNT SHALL be ignored, and the count SHALL complete.
REQ-022 clear and scan_edge in the same IDLE cycle: clear SHALL win, counters SHALL zero, the scan SHALL be dropped and the state SHALL stay IDLE.
REQ-023 item_count and disc_count SHALL saturate at 255, and stolen_count SHALL saturate at 15, with no wrap.
REQ-024 alarm SHALL be a Moore output equal to (state==ALARM).
REQ-025 Latency: scan first sampled high at clock edge k -> scan_edge true between edges k+1 and k+2 -> state COUNT/ALARM after k+2 -> counters updated after k+3; alarm high after k+2.
REQ-026 A scan held high SHALL produce exactly one event, and a new event SHALL require scan to return low for at least 2 cycles.
REQ-027 HEX0 and HEX1 SHALL be combinational from item_count.

Reset
REQ-028 reset_n low SHALL immediately force state IDLE; s1, s2, s3 and flags 0; all counters 0; alarm 0; HEX0/HEX1 showing "00" (7'b1000000).
REQ-029 reset_n asserted mid-COUNT or mid-ALARM SHALL abort with no partial increment visible after release.
REQ-030 After reset_n deasserts, a scan already high SHALL count as a new edge.

Structure
REQ-031 Package store_pkg SHALL hold the state enum (IDLE, COUNT, ALARM), CNT_W=8, STOLEN_W=4, CNT_MAX=255 and STOLEN_MAX=15.
REQ-032 Sub-module seg7_hex SHALL convert 4-bit hex to 7-bit active-low segments, instantiated twice.
REQ-033 The FSM, synchroniser and counters SHALL reside in checkout_tally.

Verification
REQ-034 Reset, then 3 scans with stolen=0/discounted=0,1,1 -> item_count=3, disc_count=2, alarm=0, HEX1/HEX0 = "03".
REQ-035 Scan with stolen=1 -> alarm=1 after k+2, stolen_count=1; 2 further scans -> no count change; clear -> alarm=0, item_count unchanged.
REQ-036 Scan held high 50 cycles -> exactly one increment; drop low for 1 cycle only, then high -> no second increment.
REQ-037 260 non-stolen discounted scans -> item_count=255, disc_count=255; 17 stolen scans each cleared -> stolen_count=15.
REQ-038 clear and scan_edge in the same IDLE cycle with item_count=5 -> counters 0, state IDLE, no increment.
REQ-039 reset_n pulsed low while in ALARM with item_count=7 -> alarm=0 and all counts 0 immediately, without a clock edge.
